// File: rtl/multicycle_ctrl_unit.sv
// rtl/multicycle_ctrl_unit.sv - registered instruction decoder with return-stack tracking, squash and halt
module multicycle_ctrl_unit #(
   parameter int INSTR_W       = 19,
   parameter int STACK_DEPTH   = 8,
   parameter int BRANCH_SHADOW = 0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               instr_valid,
   input  logic [INSTR_W-1:0]                 instruction,
   input  logic                               stall,
   input  logic                               zero,
   input  logic                               carry,
   output logic                               instr_ready,
   output logic                               ctrl_valid,
   output logic                               reg2_read_source,
   output logic                               mem_read_write,
   output logic                               mem_or_alu,
   output logic                               is_shift,
   output logic                               alu_src,
   output logic                               reg_write_signal,
   output logic                               stack_push,
   output logic                               stack_pop,
   output logic [1:0]                         pc_src,
   output logic [1:0]                         scode,
   output logic [2:0]                         acode,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
   output logic                               stack_overflow,
   output logic                               stack_underflow,
   output logic                               illegal,
   output logic                               halted
);

   localparam int T  = INSTR_W - 1;
   localparam int LW = $clog2(STACK_DEPTH + 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(STACK_DEPTH);

   typedef enum logic [1:0] {RUN, SQUASH, HALTED} state_t;

   state_t        state, state_d;
   logic          accept;
   logic          taken;
   logic [5:0]    op;
   logic          valid_d, r2_d, mrw_d, moa_d, shift_d, asrc_d, rw_d, push_d, pop_d, ill_d;
   logic [1:0]    pc_d, scode_d;
   logic [2:0]    acode_d;
   logic [LW-1:0] level_d;
   logic          ovf_d, unf_d;

   assign instr_ready = (state != HALTED) && !stall;
   assign accept      = instr_valid && instr_ready;
   assign op          = instruction[T -: 6];
   assign halted      = (state == HALTED);

   // Decode the accepted word into next-cycle controls, stack/fault updates and next state
   always_comb begin
      valid_d = 1'b0; r2_d = 1'b0; mrw_d = 1'b0; moa_d = 1'b0; shift_d = 1'b0;
      asrc_d  = 1'b0; rw_d = 1'b0; push_d = 1'b0; pop_d = 1'b0; ill_d = 1'b0;
      pc_d    = 2'b00; scode_d = 2'b00; acode_d = 3'b000;
      level_d = stack_level;
      ovf_d   = stack_overflow;
      unf_d   = stack_underflow;
      state_d = state;
      taken   = 1'b0;
      if (accept) begin
         if (state == SQUASH) begin
            // shadow slot: discard whatever was fetched, including halt/illegal words
            state_d = RUN;
         end else if (&instruction) begin
            state_d = HALTED;
         end else if (op[5] == 1'b0) begin
            valid_d = 1'b1;
            acode_d = op[3:1];
            moa_d   = 1'b1;
            rw_d    = 1'b1;
            asrc_d  = op[4];
         end else if (op[5:3] == 3'b110) begin
            valid_d = 1'b1;
            scode_d = op[2:1];
            shift_d = 1'b1;
            moa_d   = 1'b1;
            rw_d    = 1'b1;
         end else if (op[5:3] == 3'b100) begin
            valid_d = 1'b1;
            if (op[2]) begin
               ill_d = 1'b1;
            end else begin
               r2_d   = 1'b1;
               asrc_d = 1'b1;
               rw_d   = ~op[1];
               mrw_d  = op[1];
            end
         end else if (op[5:3] == 3'b101) begin
            valid_d = 1'b1;
            case (op[2:1])
               2'b00:   taken = zero;
               2'b01:   taken = ~zero;
               2'b10:   taken = carry;
               default: taken = ~carry;
            endcase
            if (taken) pc_d = 2'b01;
         end else if (op[5:2] == 4'b1110) begin
            valid_d = 1'b1;
            pc_d    = 2'b01;
            taken   = 1'b1;
            if (op[1]) begin
               // a full stack drops the push but the jump itself still goes
               if (stack_level < DEPTH_L) begin
                  push_d  = 1'b1;
                  level_d = stack_level + LW'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end else if (op == 6'b111100) begin
            valid_d = 1'b1;
            if (stack_level != '0) begin
               pop_d   = 1'b1;
               pc_d    = 2'b10;
               level_d = stack_level - LW'(1);
               taken   = 1'b1;
            end else begin
               unf_d = 1'b1;
            end
         end else begin
            valid_d = 1'b1;
            ill_d   = 1'b1;
         end
         if (taken && (BRANCH_SHADOW != 0)) state_d = SQUASH;
      end
   end

   // State, stack tracker, sticky faults and registered controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= RUN;
         stack_level      <= '0;
         stack_overflow   <= 1'b0;
         stack_underflow  <= 1'b0;
         ctrl_valid       <= 1'b0;
         reg2_read_source <= 1'b0;
         mem_read_write   <= 1'b0;
         mem_or_alu       <= 1'b0;
         is_shift         <= 1'b0;
         alu_src          <= 1'b0;
         reg_write_signal <= 1'b0;
         stack_push       <= 1'b0;
         stack_pop        <= 1'b0;
         pc_src           <= 2'b00;
         scode            <= 2'b00;
         acode            <= 3'b000;
         illegal          <= 1'b0;
      end else begin
         state            <= state_d;
         stack_level      <= level_d;
         stack_overflow   <= ovf_d;
         stack_underflow  <= unf_d;
         ctrl_valid       <= valid_d;
         reg2_read_source <= r2_d;
         mem_read_write   <= mrw_d;
         mem_or_alu       <= moa_d;
         is_shift         <= shift_d;
         alu_src          <= asrc_d;
         reg_write_signal <= rw_d;
         stack_push       <= push_d;
         stack_pop        <= pop_d;
         pc_src           <= pc_d;
         scode            <= scode_d;
         acode            <= acode_d;
         illegal          <= ill_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb/tb_multicycle_ctrl_unit.sv - table-driven and sequence checks for multicycle_ctrl_unit
module tb_multicycle_ctrl_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0, zero = 1'b0, carry = 1'b0;
   logic valid_a = 1'b0, valid_b = 1'b0;
   logic [18:0] instr_a = '0;
   logic [23:0] instr_b = '0;

   always #5 clk = ~clk;

   logic rdy_a, cv_a, r2_a, mrw_a, moa_a, sh_a, as_a, rw_a, pu_a, po_a, ovf_a, unf_a, il_a, hl_a;
   logic [1:0] pc_a, sc_a, lvl_a;
   logic [2:0] ac_a;
   logic rdy_b, cv_b, r2_b, mrw_b, moa_b, sh_b, as_b, rw_b, pu_b, po_b, ovf_b, unf_b, il_b, hl_b;
   logic [1:0] pc_b, sc_b;
   logic [3:0] lvl_b;
   logic [2:0] ac_b;

   multicycle_ctrl_unit #(.INSTR_W(19), .STACK_DEPTH(2), .BRANCH_SHADOW(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .instr_valid(valid_a), .instruction(instr_a), .stall(stall),
      .zero(zero), .carry(carry), .instr_ready(rdy_a), .ctrl_valid(cv_a), .reg2_read_source(r2_a),
      .mem_read_write(mrw_a), .mem_or_alu(moa_a), .is_shift(sh_a), .alu_src(as_a),
      .reg_write_signal(rw_a), .stack_push(pu_a), .stack_pop(po_a), .pc_src(pc_a), .scode(sc_a),
      .acode(ac_a), .stack_level(lvl_a), .stack_overflow(ovf_a), .stack_underflow(unf_a),
      .illegal(il_a), .halted(hl_a));

   multicycle_ctrl_unit #(.INSTR_W(24), .STACK_DEPTH(8), .BRANCH_SHADOW(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .instr_valid(valid_b), .instruction(instr_b), .stall(stall),
      .zero(zero), .carry(carry), .instr_ready(rdy_b), .ctrl_valid(cv_b), .reg2_read_source(r2_b),
      .mem_read_write(mrw_b), .mem_or_alu(moa_b), .is_shift(sh_b), .alu_src(as_b),
      .reg_write_signal(rw_b), .stack_push(pu_b), .stack_pop(po_b), .pc_src(pc_b), .scode(sc_b),
      .acode(ac_b), .stack_level(lvl_b), .stack_overflow(ovf_b), .stack_underflow(unf_b),
      .illegal(il_b), .halted(hl_b));

   logic [16:0] obs_a, obs_b;
   assign obs_a = {cv_a, r2_a, mrw_a, moa_a, sh_a, as_a, rw_a, pu_a, po_a, pc_a, sc_a, ac_a, il_a};
   assign obs_b = {cv_b, r2_b, mrw_b, moa_b, sh_b, as_b, rw_b, pu_b, po_b, pc_b, sc_b, ac_b, il_b};

   int checks = 0;
   int errors = 0;

   function automatic logic [16:0] ctl(input logic v, r2, mrw, moa, sh, asr, rw, pu, po,
                                       input logic [1:0] pc, sc, input logic [2:0] ac,
                                       input logic il);
      return {v, r2, mrw, moa, sh, asr, rw, pu, po, pc, sc, ac, il};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [18:0] instr;
      logic        z;
      logic        c;
      logic [16:0] exp;
      logic [1:0]  lvl;
      logic        ovf;
      logic        unf;
   } vec_t;

   vec_t vecs[18];
   logic [16:0] r_ctl, ld_ctl, st_ctl, jmp_ctl;

   initial begin
      r_ctl   = ctl(1,0,0,1,0,0,1,0,0,2'b00,2'b00,3'b011,0);
      ld_ctl  = ctl(1,1,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0);
      st_ctl  = ctl(1,1,1,0,0,1,0,0,0,2'b00,2'b00,3'b000,0);
      jmp_ctl = ctl(1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0);

      vecs[0]  = '{{6'b000110, 13'h1234}, 0, 0, r_ctl, 2'd0, 0, 0};
      vecs[1]  = '{{6'b011010, 13'h0F0F}, 0, 0, ctl(1,0,0,1,0,1,1,0,0,2'b00,2'b00,3'b101,0), 2'd0, 0, 0};
      vecs[2]  = '{{6'b110100, 13'h0001}, 0, 0, ctl(1,0,0,1,1,0,1,0,0,2'b00,2'b10,3'b000,0), 2'd0, 0, 0};
      vecs[3]  = '{{6'b100000, 13'h0AAA}, 0, 0, ld_ctl, 2'd0, 0, 0};
      vecs[4]  = '{{6'b100010, 13'h1555}, 0, 0, st_ctl, 2'd0, 0, 0};
      vecs[5]  = '{{6'b101000, 13'h0000}, 1, 0, jmp_ctl, 2'd0, 0, 0};
      vecs[6]  = '{{6'b101000, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 2'd0, 0, 0};
      vecs[7]  = '{{6'b101110, 13'h0000}, 0, 0, jmp_ctl, 2'd0, 0, 0};
      vecs[8]  = '{{6'b101100, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 2'd0, 0, 0};
      vecs[9]  = '{{6'b111000, 13'h0040}, 0, 0, jmp_ctl, 2'd0, 0, 0};
      vecs[10] = '{{6'b111010, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,1,0,2'b01,2'b00,3'b000,0), 2'd1, 0, 0};
      vecs[11] = '{{6'b111010, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,1,0,2'b01,2'b00,3'b000,0), 2'd2, 0, 0};
      vecs[12] = '{{6'b111010, 13'h0000}, 0, 0, jmp_ctl, 2'd2, 1, 0};
      vecs[13] = '{{6'b111100, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0), 2'd1, 1, 0};
      vecs[14] = '{{6'b111100, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0), 2'd0, 1, 0};
      vecs[15] = '{{6'b111100, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0), 2'd0, 1, 1};
      vecs[16] = '{{6'b100100, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1), 2'd0, 1, 1};
      vecs[17] = '{{6'b111110, 13'h0000}, 0, 0, ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1), 2'd0, 1, 1};

      // reset state
      cyc();
      cyc();
      chk("rst_ctl", 32'(obs_a), 32'h0);
      chk("rst_level", 32'(lvl_a), 32'h0);
      chk("rst_flags", 32'({ovf_a, unf_a, hl_a}), 32'h0);
      chk("rst_ready", 32'(rdy_a), 32'h1);
      stall = 1'b1;
      #1;
      chk("ready_follows_stall", 32'(rdy_a), 32'h0);
      stall = 1'b0;
      rst_n = 1'b1;

      // decode table on the 19-bit, depth-2, no-shadow unit
      for (int i = 0; i < 18; i++) begin
         instr_a = vecs[i].instr;
         zero    = vecs[i].z;
         carry   = vecs[i].c;
         valid_a = 1'b1;
         cyc();
         chk($sformatf("vec%0d_ctl", i), 32'(obs_a), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_level", i), 32'(lvl_a), 32'(vecs[i].lvl));
         chk($sformatf("vec%0d_faults", i), 32'({ovf_a, unf_a}), 32'({vecs[i].ovf, vecs[i].unf}));
      end
      valid_a = 1'b0;
      cyc();
      chk("bubble_after_illegal", 32'(obs_a), 32'h0);

      // stall with a jsb presented: nothing moves
      instr_a = {6'b111010, 13'h0};
      valid_a = 1'b1;
      cyc();
      chk("jsb_before_stall", 32'(lvl_a), 32'h1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("stall%0d_ctl", k), 32'(obs_a), 32'h0);
         chk($sformatf("stall%0d_level", k), 32'(lvl_a), 32'h1);
         chk($sformatf("stall%0d_halted", k), 32'(hl_a), 32'h0);
      end
      stall = 1'b0;

      // halt, then asynchronous reset out of HALTED
      instr_a = '1;
      cyc();
      chk("halt_ctl", 32'(obs_a), 32'h0);
      chk("halt_halted", 32'(hl_a), 32'h1);
      chk("halt_ready", 32'(rdy_a), 32'h0);
      instr_a = {6'b000110, 13'h0};
      cyc();
      chk("halt_hold_ctl", 32'(obs_a), 32'h0);
      chk("halt_hold_halted", 32'(hl_a), 32'h1);
      chk("halt_hold_level", 32'(lvl_a), 32'h1);
      rst_n = 1'b0;
      #2;
      chk("async_rst_level", 32'(lvl_a), 32'h0);
      chk("async_rst_flags", 32'({ovf_a, unf_a, hl_a}), 32'h0);
      chk("async_rst_ready", 32'(rdy_a), 32'h1);
      chk("async_rst_ctl", 32'(obs_a), 32'h0);
      valid_a = 1'b0;
      cyc();
      rst_n = 1'b1;
      instr_a = {6'b000110, 13'h0};
      valid_a = 1'b1;
      cyc();
      chk("run_after_reset", 32'(obs_a), 32'(r_ctl));
      valid_a = 1'b0;

      // 24-bit unit with branch shadow
      valid_b = 1'b1;
      instr_b = {6'b000110, 18'h2AAAA};
      cyc();
      chk("w24_rtype", 32'(obs_b), 32'(r_ctl));
      instr_b = {6'b111000, 18'h0};
      cyc();
      chk("w24_jump", 32'(obs_b), 32'(jmp_ctl));
      instr_b = {6'b100000, 18'h0};
      cyc();
      chk("shadow_load_squashed", 32'(obs_b), 32'h0);
      instr_b = {6'b100010, 18'h0};
      cyc();
      chk("shadow_store_after", 32'(obs_b), 32'(st_ctl));
      instr_b = {6'b111000, 18'h0};
      cyc();
      chk("w24_jump2", 32'(obs_b), 32'(jmp_ctl));
      valid_b = 1'b0;
      cyc();
      cyc();
      chk("squash_idle", 32'(obs_b), 32'h0);
      valid_b = 1'b1;
      instr_b = '1;
      cyc();
      chk("squashed_halt_ctl", 32'(obs_b), 32'h0);
      chk("squashed_halt_not_halted", 32'(hl_b), 32'h0);
      instr_b = {6'b100010, 18'h0};
      cyc();
      chk("store_after_squash", 32'(obs_b), 32'(st_ctl));
      chk("w24_still_running", 32'({hl_b, rdy_b}), 32'h1);
      valid_b = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
